// File: rtl/fcvt_pre.sv
// Integer-to-float pre-normalization: two-stage pipeline producing sign,
// left-normalized magnitude and biased exponent for fcvt.s.w / fcvt.s.wu.
module fcvt_pre #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [7:0]       out_exp,
    output logic [31:0]      out_norm,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on any edge where valid & ready are both 1;
    // valid never depends on ready, and data is held while valid & !ready.
    logic             v1, v2;
    logic             adv2, accept;

    logic             s1_sign;
    logic [31:0]      s1_mag;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_sign;
    logic [7:0]       s2_exp;
    logic [31:0]      s2_norm;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    logic             in_sign;
    logic [31:0]      in_mag;
    logic [4:0]       lz;
    logic [31:0]      sh;
    logic             mag_zero;

    assign adv2     = v1 & (~v2 | out_ready);
    assign in_ready = ~flush & (~v1 | adv2);
    assign accept   = in_valid & in_ready;

    assign in_sign  = in_signed & in_x[31];
    assign in_mag   = in_sign ? (~in_x + 32'd1) : in_x;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (accept)
                v1 <= 1'b1;
            else if (adv2)
                v1 <= 1'b0;
            if (adv2)
                v2 <= 1'b1;
            else if (out_ready)
                v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_tag  <= '0;
        end else if (accept) begin
            s1_sign <= in_sign;
            s1_mag  <= in_mag;
            s1_tag  <= in_tag;
        end
    end

    // Five-level binary normalizer: each level tests the top half of what is
    // left and shifts, so the count bits fall out MSB first with no iteration.
    always_comb begin
        lz = '0;
        sh = s1_mag;
        if (sh[31:16] == 16'd0) begin
            lz[4] = 1'b1;
            sh    = {sh[15:0], 16'd0};
        end
        if (sh[31:24] == 8'd0) begin
            lz[3] = 1'b1;
            sh    = {sh[23:0], 8'd0};
        end
        if (sh[31:28] == 4'd0) begin
            lz[2] = 1'b1;
            sh    = {sh[27:0], 4'd0};
        end
        if (sh[31:30] == 2'd0) begin
            lz[1] = 1'b1;
            sh    = {sh[29:0], 2'd0};
        end
        if (sh[31] == 1'b0) begin
            lz[0] = 1'b1;
            sh    = {sh[30:0], 1'b0};
        end
    end

    assign mag_zero = (s1_mag == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_norm <= '0;
            s2_zero <= 1'b0;
            s2_tag  <= '0;
        end else if (adv2) begin
            s2_sign <= s1_sign & ~mag_zero;
            s2_exp  <= mag_zero ? 8'd0 : (8'd158 - {3'b000, lz});
            s2_norm <= mag_zero ? 32'd0 : sh;
            s2_zero <= mag_zero;
            s2_tag  <= s1_tag;
        end
    end

    assign out_valid = v2;
    assign out_sign  = s2_sign;
    assign out_exp   = s2_exp;
    assign out_norm  = s2_norm;
    assign out_zero  = s2_zero;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_fcvt_pre.sv
// Self-checking bench for fcvt_pre: directed conversions, stall, flush,
// mid-stream reset and a randomized backpressure stream against a scoreboard.
module tb_fcvt_pre;

    localparam int TW = 5;
    localparam int PW = 1 + 8 + 32 + 1 + TW;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_x;
    logic          in_signed;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [7:0]    out_exp;
    logic [31:0]   out_norm;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    logic [PW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;
    logic          rand_done;

    fcvt_pre #(.TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_exp(out_exp), .out_norm(out_norm), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [PW-1:0] pk(input logic s, input logic [7:0] e,
                                         input logic [31:0] n, input logic z,
                                         input logic [TW-1:0] t);
        return {s, e, n, z, t};
    endfunction

    // Reference: count leading zeros bit by bit from the top.
    function automatic logic [PW-1:0] model(input logic [31:0] x, input logic s,
                                            input logic [TW-1:0] t);
        logic        sg;
        logic [31:0] m;
        int          lzc;
        sg = s & x[31];
        m  = sg ? (32'd0 - x) : x;
        if (m == 32'd0)
            return pk(1'b0, 8'd0, 32'd0, 1'b1, t);
        lzc = 0;
        while (m[31-lzc] == 1'b0)
            lzc++;
        return pk(sg, 8'(158 - lzc), m << lzc, 1'b0, t);
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] x, input logic s, input logic [TW-1:0] t,
                        input logic [PW-1:0] want);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_x      = x;
        in_signed = s;
        in_tag    = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(want);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok)
            check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          prev_hold;
    logic [PW-1:0] prev_out;

    initial begin
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_hold && out_valid)
                    check("hold_stable", 64'({out_sign, out_exp, out_norm, out_zero, out_tag}),
                          64'(prev_out));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_out", 64'(out_tag), 64'hFFFF_FFFF);
                    else
                        check("result", 64'({out_sign, out_exp, out_norm, out_zero, out_tag}),
                              64'(exp_q.pop_front()));
                end
            end
            prev_hold = out_valid & ~out_ready & ~rst & ~flush;
            prev_out  = {out_sign, out_exp, out_norm, out_zero, out_tag};
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] stream_x[6];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rand_done = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        stream_x  = '{32'h10, 32'h300, 32'h7, 32'h1234_5678, 32'h1, 32'h800};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'({out_sign, out_exp, out_norm, out_zero, out_tag}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed conversions with hand-computed results.
        send(32'h0000_0001, 1'b0, 5'd3, pk(1'b0, 8'd127, 32'h8000_0000, 1'b0, 5'd3));
        @(negedge clk);
        check("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 1'b1, 5'd4, pk(1'b1, 8'd127, 32'h8000_0000, 1'b0, 5'd4));
        send(32'h8000_0000, 1'b1, 5'd5, pk(1'b1, 8'd158, 32'h8000_0000, 1'b0, 5'd5));
        send(32'hFFFF_FFFF, 1'b0, 5'd6, pk(1'b0, 8'd158, 32'hFFFF_FFFF, 1'b0, 5'd6));
        send(32'h0000_0000, 1'b1, 5'd7, pk(1'b0, 8'd0, 32'h0000_0000, 1'b1, 5'd7));
        send(32'h8000_0000, 1'b0, 5'd8, pk(1'b0, 8'd158, 32'h8000_0000, 1'b0, 5'd8));
        repeat (4) @(posedge clk);
        #1;

        // Stream of six with the consumer stalled at the start.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(stream_x[i], 1'b0, TW'(i + 1), model(stream_x[i], 1'b0, TW'(i + 1)));
            end
            begin
                repeat (2) @(posedge clk);
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_accepts", 64'(exp_q.size()), 64'd2);
                    check("stall_tag", 64'(out_tag), 64'd1);
                    check("stall_exp", 64'(out_exp), 64'd131);
                    check("stall_norm", 64'(out_norm), 64'h8000_0000);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Flush with both stages occupied and a request waiting.
        out_ready = 1'b0;
        send(32'h0000_00F0, 1'b0, 5'd10, model(32'h0000_00F0, 1'b0, 5'd10));
        send(32'hFFFF_FF00, 1'b1, 5'd11, model(32'hFFFF_FF00, 1'b1, 5'd11));
        in_valid = 1'b1;
        in_x     = 32'h0000_0055;
        in_tag   = 5'd12;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h0001_0000, 1'b0, 5'd13, pk(1'b0, 8'd143, 32'h8000_0000, 1'b0, 5'd13));
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-stream with both stages occupied.
        out_ready = 1'b0;
        send(32'h0000_0003, 1'b1, 5'd20, model(32'h0000_0003, 1'b1, 5'd20));
        send(32'hF000_0000, 1'b1, 5'd21, model(32'hF000_0000, 1'b1, 5'd21));
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'({out_sign, out_exp, out_norm, out_zero, out_tag}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Random operands under random backpressure.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] x;
                    logic        s;
                    logic [TW-1:0] t;
                    x = $urandom() >> $urandom_range(0, 31);
                    if ($urandom_range(0, 9) == 0)
                        x = 32'd0;
                    if ($urandom_range(0, 3) == 0)
                        x = ~x;
                    s = 1'($urandom_range(0, 1));
                    t = TW'($urandom_range(0, 31));
                    send(x, s, t, model(x, s, t));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 200 && exp_q.size() > 0; i++)
            @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fcvt_pre.md
# fcvt_pre

Pipelined pre-normalization stage that feeds the integer-to-float rounding/packing stage of the FPU conversion path. Each request is a 32-bit integer operand, interpreted as signed (fcvt.s.w) or unsigned (fcvt.s.wu). For each request the block produces the sign, the absolute magnitude left-normalized so that bit 31 is 1, and the biased exponent. It has two register stages with valid/ready handshakes on both sides, so it can stall behind a busy consumer and be flushed by the core.

## Interface

Parameters:
- TAG_W, default 5: width of the opaque tag (destination register index) carried alongside each request.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight requests.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts a request this cycle.
- in_x  input  32  integer operand.
- in_signed  input  1  1 = treat in_x as two's complement; 0 = treat it as unsigned.
- in_tag  input  TAG_W  tag, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sign  output  1  sign of the result.
- out_exp  output  8  biased exponent.
- out_norm  output  32  normalized magnitude; bit 31 = 1 unless out_zero is 1.
- out_zero  output  1  operand was zero.
- out_tag  output  TAG_W  tag of the result.

## Operation

Stage 1 (S1), registered on acceptance:
- sign = in_signed & in_x[31].
- mag = sign ? (~in_x + 1) : in_x, held in 32 bits.
- Signed 0x80000000 gives mag 0x80000000. No overflow handling is needed.

Stage 2 (S2), registered when S1 advances:
- lzc = number of leading zeros of mag, in the range 0..31. For mag = 0, lzc is don't-care.
- norm = mag << lzc.
- exp = 158 − lzc, an 8-bit unsigned value in the range 127..158.
- zero = (mag == 0). When zero = 1, the block forces sign = 0, exp = 0 and norm = 0.
- The tag travels with its request through both stages.

The outputs are driven directly from the S2 registers; there is no combinational path from in_x to any out_* port.

Handshake and advance rules:
- Each stage has a valid bit: v1 for S1, v2 for S2.
- S2 releases its entry when out_ready is 1.
- adv2 = v1 & (!v2 | out_ready).
- in_ready = !flush & (!v1 | adv2).
- An input is accepted on in_valid & in_ready.
- out_valid = v2. Data on out_* is stable while out_valid = 1 and out_ready = 0.
- No bubbles: throughput is one request per cycle while out_ready is held at 1.
- Requests leave in the same order they were accepted.

Flush:
- When flush is asserted, v1 and v2 clear at the next edge.
- Nothing is accepted in a flush cycle, because in_ready = 0.
- If out_valid and out_ready are both 1 in a flush cycle, the transfer still counts as completed by the consumer. The flush clears only what remains.

Reset:
- rst takes priority over flush and over every handshake.
- After reset, v1 = v2 = 0, so out_valid = 0.
- All data registers reset to 0, so out_sign, out_exp, out_norm, out_zero and out_tag all read 0.
- in_ready = 1 in the first cycle after reset releases, provided flush = 0.

## Timing

- Latency: a request accepted at edge N appears with out_valid = 1 after edge N+1, when out_ready was not stalling.
- Capacity: 2 requests (S1 + S2).
- With out_ready held at 0 and in_valid held at 1:
  - the block accepts exactly 2 requests;
  - in_ready then drops combinationally in the cycle v1 = v2 = 1;
  - in_ready stays low until out_ready rises.
- Simultaneous drain and fill at full occupancy: in the cycle out_ready = 1 with v1 = v2 = 1, in_ready = 1. S2 takes S1's entry and S1 takes the new request at the same edge.
- Combinational paths:
  - out_ready → in_ready is the only combinational path through the block.
  - flush also drives in_ready combinationally.
- Timing closure: the leading-zero count plus shifter in S2 must close at the core clock. A priority tree is acceptable; the iterative approach is not.

## Test plan

- Reset, then unsigned in_x = 0x00000001, tag 3 → two cycles later out_valid = 1, sign 0, exp 127, norm 0x80000000, zero 0, tag 3.
- Signed 0xFFFFFFFF → sign 1, exp 127, norm 0x80000000.
- Signed 0x80000000 → sign 1, exp 158, norm 0x80000000.
- Unsigned 0xFFFFFFFF → sign 0, exp 158, norm 0xFFFFFFFF.
- Signed 0x00000000 → zero 1, sign 0, exp 0, norm 0.
- Stream tags 1..6 of unsigned values 0x10, 0x300, 0x7, 0x12345678, 0x1, 0x800 with out_ready = 0 for cycles 2–5 →
  - in_ready falls after 2 accepts;
  - results emerge in tag order 1..6 with no loss or duplication;
  - the tag-1 output is held stable throughout the stall (e.g. 0x10 → exp 131, norm 0x80000000).
- Flush with 2 entries held and in_valid = 1 → in_ready = 0 in the flush cycle; out_valid = 0 the next cycle; the next request is accepted and emerges normally.
- Assert rst mid-stream with v1 = v2 = 1 → all outputs read 0 and out_valid = 0 at the next cycle; in_ready = 1 after reset releases.
